// File: rtl/imem_arbiter.sv
// Round-robin sharing of one single-port instruction memory between the fetch stage
// and the loader, with a 2-entry in-order response FIFO per requester.

module imem_arbiter_fifo #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic [1:0]    cnt
);
   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          do_pop;

   always_comb begin
      ent0_d   = ent0_q;
      ent1_d   = ent1_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_pop   = pop & (cnt_q != 2'd0);
      if (clr) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr_q) ent1_d = push_data;
            else          ent0_d = push_data;
            wr_ptr_d = ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid = (cnt_q != 2'd0);
   assign data  = rd_ptr_q ? ent1_q : ent0_q;
   assign cnt   = cnt_q;
endmodule

module imem_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  f_req_valid,
   output logic                  f_req_ready,
   input  logic [AW-1:0]         f_req_addr,
   output logic                  f_rsp_valid,
   input  logic                  f_rsp_ready,
   output logic [DW-1:0]         f_rsp_data,
   input  logic                  f_flush,
   input  logic                  l_req_valid,
   output logic                  l_req_ready,
   input  logic                  l_req_we,
   input  logic [AW-1:0]         l_req_addr,
   input  logic [DW-1:0]         l_req_wdata,
   output logic                  l_rsp_valid,
   input  logic                  l_rsp_ready,
   output logic [DW-1:0]         l_rsp_data,
   input  logic                  l_lock,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic [DW-1:0]         mem_rdata
);
   logic       rr_q, rr_d;
   logic       rd_vld_q, rd_vld_d;
   logic       rd_own_q, rd_own_d;
   logic       rd_f_infl, rd_l_infl;
   logic [1:0] f_cnt, l_cnt;
   logic [1:0] outst_f, outst_l;
   logic       f_fire, l_fire;
   logic       f_elig, l_elig;
   logic       gnt_f, gnt_l;
   logic       f_push, l_push;
   logic       unused_addr_bits;

   assign f_fire    = f_rsp_valid & f_rsp_ready;
   assign l_fire    = l_rsp_valid & l_rsp_ready;
   assign rd_f_infl = rd_vld_q & ~rd_own_q;
   assign rd_l_infl = rd_vld_q &  rd_own_q;
   assign outst_f   = {1'b0, rd_f_infl} + f_cnt;
   assign outst_l   = {1'b0, rd_l_infl} + l_cnt;

   // Grants are gated by rst_n so the memory strobe and readies drop the moment reset asserts.
   always_comb begin
      f_elig = rst_n & f_req_valid & ~l_lock & ~f_flush & ((outst_f < 2'd2) | f_fire);
      if (l_req_we) l_elig = rst_n & l_req_valid & l_lock;
      else          l_elig = rst_n & l_req_valid & ((outst_l < 2'd2) | l_fire);
      gnt_f = f_elig & (~l_elig | ~rr_q);
      gnt_l = l_elig & (~f_elig |  rr_q);
   end

   always_comb begin
      rr_d      = rr_q;
      mem_en    = gnt_f | gnt_l;
      mem_we    = gnt_l & l_req_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_f) begin
         mem_addr = f_req_addr[DEPTH_LOG2+1:2];
         rr_d     = 1'b1;
      end else if (gnt_l) begin
         mem_addr = l_req_addr[DEPTH_LOG2+1:2];
         rr_d     = 1'b0;
      end
      if (mem_we) mem_wdata = l_req_wdata;
      rd_vld_d = mem_en & ~mem_we;
      rd_own_d = gnt_l;
   end

   assign f_req_ready = gnt_f;
   assign l_req_ready = gnt_l;

   // A fetch read landing during a flush cycle is dropped rather than queued.
   assign f_push = rd_f_infl & ~f_flush;
   assign l_push = rd_l_infl;

   assign unused_addr_bits = ^{f_req_addr[AW-1:DEPTH_LOG2+2], f_req_addr[1:0],
                               l_req_addr[AW-1:DEPTH_LOG2+2], l_req_addr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= 1'b0;
         rd_vld_q <= 1'b0;
         rd_own_q <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         rd_vld_q <= rd_vld_d;
         rd_own_q <= rd_own_d;
      end
   end

   imem_arbiter_fifo #(.DW(DW)) u_f_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (f_flush),
      .push      (f_push),
      .push_data (mem_rdata),
      .pop       (f_rsp_ready),
      .valid     (f_rsp_valid),
      .data      (f_rsp_data),
      .cnt       (f_cnt)
   );

   imem_arbiter_fifo #(.DW(DW)) u_l_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (1'b0),
      .push      (l_push),
      .push_data (mem_rdata),
      .pop       (l_rsp_ready),
      .valid     (l_rsp_valid),
      .data      (l_rsp_data),
      .cnt       (l_cnt)
   );
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: behavioural memory macro, response scoreboard, vector table
// and hand-written sequences for reset, streaming, contention, backpressure, flush and lock.

module tb_imem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DL = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_flush;
   logic [AW-1:0] f_req_addr;
   logic [DW-1:0] f_rsp_data;
   logic          l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_lock;
   logic [AW-1:0] l_req_addr;
   logic [DW-1:0] l_req_wdata, l_rsp_data;
   logic          mem_en, mem_we;
   logic [DL-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int f_fire_cnt = 0;

   logic [31:0] mem_arr [int];
   logic [31:0] exp_wr  [int];
   logic [31:0] f_q [$];
   logic [31:0] l_q [$];

   typedef struct {
      bit          fv, lv, lwe, lock, flush;
      logic [31:0] fa, la, lwd;
      bit          efr, elr, ewe;
      logic [11:0] emaddr;
   } vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   imem_arbiter #(.DW(DW), .AW(AW), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
      .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
      .f_flush(f_flush),
      .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
      .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
      .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data),
      .l_lock(l_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] pat(input int idx);
      return 32'hC0DE_0000 + idx;
   endfunction

   function automatic logic [31:0] exp_word(input int idx);
      if (exp_wr.exists(idx)) return exp_wr[idx];
      return pat(idx);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      f_req_valid = 1'b0;
      l_req_valid = 1'b0;
      l_req_we    = 1'b0;
      f_flush     = 1'b0;
      l_lock      = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      f_req_valid = 0; f_req_addr = '0; f_rsp_ready = 1; f_flush = 0;
      l_req_valid = 0; l_req_we = 0; l_req_addr = '0; l_req_wdata = '0;
      l_rsp_ready = 1; l_lock = 0;
      mem_rdata   = '0;

      vecs[0]  = '{1,0,0,0,0, 32'h10,         32'h0,         32'h0,         1,0,0, 12'h004};
      vecs[1]  = '{1,1,0,0,0, 32'h14,         32'h24,        32'h0,         0,1,0, 12'h009};
      vecs[2]  = '{1,1,0,0,0, 32'h18,         32'h28,        32'h0,         1,0,0, 12'h006};
      vecs[3]  = '{0,1,1,0,0, 32'h0,          32'h30,        32'h5555_AAAA, 0,0,0, 12'h000};
      vecs[4]  = '{1,0,0,1,0, 32'h1C,         32'h0,         32'h0,         0,0,0, 12'h000};
      vecs[5]  = '{1,1,1,1,0, 32'h1C,         32'h200,       32'h1234_5678, 0,1,1, 12'h080};
      vecs[6]  = '{1,0,0,0,1, 32'h20,         32'h0,         32'h0,         0,0,0, 12'h000};
      vecs[7]  = '{1,1,0,0,1, 32'h20,         32'h200,       32'h0,         0,1,0, 12'h080};
      vecs[8]  = '{1,1,0,0,0, 32'h24,         32'h34,        32'h0,         1,0,0, 12'h009};
      vecs[9]  = '{0,0,0,0,0, 32'h0,          32'h0,         32'h0,         0,0,0, 12'h000};
      vecs[10] = '{1,1,0,0,0, 32'h28,         32'hFFFF_0104, 32'h0,         0,1,0, 12'h041};
      vecs[11] = '{1,0,0,0,0, 32'h8000_4008,  32'h0,         32'h0,         1,0,0, 12'h002};

      fork
         // Memory macro: synchronous, one-cycle read latency.
         forever begin
            @(posedge clk);
            if (mem_en) begin
               if (mem_we) mem_arr[int'(mem_addr)] = mem_wdata;
               else mem_rdata <= mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)]
                                                                : pat(int'(mem_addr));
            end
         end
         // Scoreboard: expected data queued on accept, compared on response handshake.
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (f_rsp_valid && f_rsp_ready) begin
                  f_fire_cnt++;
                  if (f_q.size() == 0) chk("f_rsp_unexpected", 32'd1, 32'd0);
                  else chk("f_rsp_data", f_rsp_data, f_q.pop_front());
               end
               if (l_rsp_valid && l_rsp_ready) begin
                  if (l_q.size() == 0) chk("l_rsp_unexpected", 32'd1, 32'd0);
                  else chk("l_rsp_data", l_rsp_data, l_q.pop_front());
               end
               if (f_req_valid && f_req_ready)
                  f_q.push_back(exp_word(int'(f_req_addr[DL+1:2])));
               if (l_req_valid && l_req_ready) begin
                  if (l_req_we) exp_wr[int'(l_req_addr[DL+1:2])] = l_req_wdata;
                  else l_q.push_back(exp_word(int'(l_req_addr[DL+1:2])));
               end
               if (f_flush) f_q.delete();
            end
         end
      join_none

      // Reset state
      repeat (3) step();
      chk("rst_f_req_ready", {31'd0, f_req_ready}, 32'd0);
      chk("rst_f_rsp_valid", {31'd0, f_rsp_valid}, 32'd0);
      chk("rst_l_rsp_valid", {31'd0, l_rsp_valid}, 32'd0);
      chk("rst_mem_en",      {31'd0, mem_en},      32'd0);
      rst_n = 1'b1;
      step();

      // Contention right after reset: fetch first, then alternate
      f_req_valid = 1; f_req_addr = 32'h10;
      l_req_valid = 1; l_req_addr = 32'h20; l_req_we = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("cont_f_ready", {31'd0, f_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_l_ready", {31'd0, l_req_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
         step();
      end
      idle(4);

      // Vector table, each applied for one cycle from an idle state
      for (int v = 0; v < 12; v++) begin
         f_req_valid = vecs[v].fv;   f_req_addr  = vecs[v].fa;
         l_req_valid = vecs[v].lv;   l_req_addr  = vecs[v].la;
         l_req_we    = vecs[v].lwe;  l_req_wdata = vecs[v].lwd;
         l_lock      = vecs[v].lock; f_flush     = vecs[v].flush;
         @(negedge clk);
         chk("vec_f_ready", {31'd0, f_req_ready}, {31'd0, vecs[v].efr});
         chk("vec_l_ready", {31'd0, l_req_ready}, {31'd0, vecs[v].elr});
         chk("vec_mem_en",  {31'd0, mem_en},      {31'd0, vecs[v].efr | vecs[v].elr});
         chk("vec_mem_we",  {31'd0, mem_we},      {31'd0, vecs[v].ewe});
         if (vecs[v].efr | vecs[v].elr)
            chk("vec_mem_addr", {20'd0, mem_addr}, {20'd0, vecs[v].emaddr});
         step();
         idle(3);
      end

      // Streaming: 8 back-to-back fetches, responses one per cycle
      f_fire_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         f_req_valid = 1; f_req_addr = 32'(i * 4);
         @(negedge clk);
         chk("stream_ready", {31'd0, f_req_ready}, 32'd1);
         chk("stream_addr",  {20'd0, mem_addr},    32'(i));
         step();
      end
      f_req_valid = 0;
      step(); step();
      chk("stream_rsp_count", 32'(f_fire_cnt), 32'd8);
      idle(2);

      // Reset mid-stream, then a clean first fetch with latency 2
      f_req_valid = 1; f_req_addr = 32'h8;
      l_req_valid = 1; l_req_addr = 32'h44;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("mrst_f_req_ready", {31'd0, f_req_ready}, 32'd0);
      chk("mrst_l_req_ready", {31'd0, l_req_ready}, 32'd0);
      chk("mrst_f_rsp_valid", {31'd0, f_rsp_valid}, 32'd0);
      chk("mrst_l_rsp_valid", {31'd0, l_rsp_valid}, 32'd0);
      chk("mrst_mem_en",      {31'd0, mem_en},      32'd0);
      chk("mrst_mem_we",      {31'd0, mem_we},      32'd0);
      f_q.delete();
      l_q.delete();
      idle(2);
      rst_n = 1'b1;
      step();
      f_req_valid = 1; f_req_addr = 32'h0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, f_req_ready}, 32'd1);
      chk("post_rst_addr",  {20'd0, mem_addr},    32'd0);
      step();
      f_req_valid = 0;
      @(negedge clk);
      chk("post_rst_t1_valid", {31'd0, f_rsp_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("post_rst_t2_valid", {31'd0, f_rsp_valid}, 32'd1);
      chk("post_rst_t2_data",  f_rsp_data,          pat(0));
      idle(3);

      // Backpressure: consumer stalled, only two fetches accepted
      begin
         int acc;
         acc = 0;
         f_rsp_ready = 0;
         for (int c = 0; c < 6; c++) begin
            f_req_valid = 1; f_req_addr = 32'h80 + 32'(acc * 4);
            @(negedge clk);
            chk("bp_ready", {31'd0, f_req_ready}, (c < 2) ? 32'd1 : 32'd0);
            if (f_req_ready) acc++;
            step();
         end
         chk("bp_accepted", 32'(acc), 32'd2);
         chk("bp_head_data", f_rsp_data, pat(32));
         f_rsp_ready = 1;
         f_req_addr  = 32'h80 + 32'(acc * 4);
         @(negedge clk);
         chk("bp_ready_on_pop", {31'd0, f_req_ready}, 32'd1);
         step();
         idle(4);
      end

      // Flush drops the in-flight fetch; the next fetch proceeds normally
      f_req_valid = 1; f_req_addr = 32'h40;
      @(negedge clk);
      chk("fl_accept", {31'd0, f_req_ready}, 32'd1);
      step();
      f_flush = 1; f_req_addr = 32'h44;
      @(negedge clk);
      chk("fl_ready_in_flush", {31'd0, f_req_ready}, 32'd0);
      step();
      f_flush = 0; f_req_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fl_no_rsp", {31'd0, f_rsp_valid}, 32'd0);
         step();
      end
      f_req_valid = 1; f_req_addr = 32'h48;
      @(negedge clk);
      chk("fl_next_accept", {31'd0, f_req_ready}, 32'd1);
      step();
      idle(3);

      // Locked write then read-back; fetch blocked throughout
      l_lock = 1;
      f_req_valid = 1; f_req_addr = 32'h0;
      l_req_valid = 1; l_req_we = 1; l_req_addr = 32'h100; l_req_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("lk_w_l_ready", {31'd0, l_req_ready}, 32'd1);
      chk("lk_w_f_ready", {31'd0, f_req_ready}, 32'd0);
      chk("lk_w_mem_we",  {31'd0, mem_we},      32'd1);
      chk("lk_w_addr",    {20'd0, mem_addr},    32'h40);
      chk("lk_w_wdata",   mem_wdata,            32'hDEAD_BEEF);
      step();
      l_req_we = 0;
      @(negedge clk);
      chk("lk_r_l_ready", {31'd0, l_req_ready}, 32'd1);
      chk("lk_r_f_ready", {31'd0, f_req_ready}, 32'd0);
      step();
      l_req_valid = 0;
      @(negedge clk);
      chk("lk_f_blocked", {31'd0, f_req_ready}, 32'd0);
      step();
      @(negedge clk);
      chk("lk_rd_valid", {31'd0, l_rsp_valid}, 32'd1);
      chk("lk_rd_data",  l_rsp_data,          32'hDEAD_BEEF);
      step();
      idle(4);

      chk("f_q_drained", 32'(f_q.size()), 32'd0);
      chk("l_q_drained", 32'(l_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
